note_hit_judge: RTL and testbench

Judges drum presses against incoming notes for one drum lane and emits single-cycle score pulses. It sits directly upstream of the score counter: `score_inc` drives the counter's increase input, and the game FSM's play state drives `game_active`. It also produces hit/miss strobes and a running combo count for the display path.

---
 rtl/taiko_pkg.sv | 30 +++
 rtl/rising_edge_detect.sv | 30 +++
 rtl/note_hit_judge.sv | 175 +++++++++++++++++
 tb/tb_note_hit_judge.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/taiko_pkg.sv
`default_nettype none
// ============================================================================
// Module      : taiko_pkg
// Description : Shared types and constants for the drum-lane judging logic.
//               - judge_state_t : IDLE / WINDOW / AWARD2 state encoding
//               - NOTE_DON / NOTE_KA : note-type codes
//               - COMBO_W / COMBO_MAX : combo counter width and saturation
// Revision    : 1.0 - initial release
// ============================================================================
package taiko_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WINDOW = 2'd1,
        ST_AWARD2 = 2'd2
    } judge_state_t;

    localparam logic NOTE_DON = 1'b0;
    localparam logic NOTE_KA  = 1'b1;

    localparam int               COMBO_W   = 8;
    localparam logic [COMBO_W-1:0] COMBO_MAX = 8'd255;

    // Increment that sticks at COMBO_MAX instead of wrapping.
    function automatic logic [COMBO_W-1:0] combo_bump(input logic [COMBO_W-1:0] c);
        return (c == COMBO_MAX) ? c : c + COMBO_W'(1);
    endfunction

endpackage : taiko_pkg
`default_nettype wire

// File: rtl/rising_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : rising_edge_detect
// Description : One-cycle pulse on a 0->1 transition of a synchronised level.
//               Ports: clock, reset (sync, active-high), level (in),
//                      pulse (out, combinational from level and history).
// Revision    : 1.0 - initial release
// ============================================================================
module rising_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic r_prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev_q <= 1'b0;
        end else begin
            r_prev_q <= level;
        end
    end

    // A held level matches its history and so never re-triggers.
    assign pulse = level & ~r_prev_q;

endmodule : rising_edge_detect
`default_nettype wire

// File: rtl/note_hit_judge.sv
`default_nettype none
// ============================================================================
// Module      : note_hit_judge
// Description : Judges drum presses against arriving notes for one lane and
//               emits registered score / hit strobes plus a combo count.
//               Inputs : clock, reset, game_active, note_arrive, note_type,
//                        drum_don, drum_ka
//               Outputs: score_inc, hit_great, hit_good, hit_miss, combo[7:0]
// Revision    : 1.0 - initial release
// ============================================================================
module note_hit_judge
    import taiko_pkg::*;
#(
    parameter int WINDOW_CYCLES = 2_500_000,
    parameter int GREAT_CYCLES  = 1_000_000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               game_active,
    input  logic               note_arrive,
    input  logic               note_type,
    input  logic               drum_don,
    input  logic               drum_ka,
    output logic               score_inc,
    output logic               hit_great,
    output logic               hit_good,
    output logic               hit_miss,
    output logic [COMBO_W-1:0] combo
);

    localparam int                  TIMER_W = $clog2(WINDOW_CYCLES);
    localparam logic [TIMER_W-1:0]  GREAT_T = TIMER_W'(GREAT_CYCLES);
    localparam logic [TIMER_W-1:0]  LAST_T  = TIMER_W'(WINDOW_CYCLES - 1);

    logic w_don_press;
    logic w_ka_press;

    rising_edge_detect u_edge_don (
        .clock (clock),
        .reset (reset),
        .level (drum_don),
        .pulse (w_don_press)
    );

    rising_edge_detect u_edge_ka (
        .clock (clock),
        .reset (reset),
        .level (drum_ka),
        .pulse (w_ka_press)
    );

    judge_state_t         r_state_q, w_state_d;
    logic [TIMER_W-1:0]   r_timer_q, w_timer_d;
    logic                 r_type_q,  w_type_d;
    logic [COMBO_W-1:0]   r_combo_q, w_combo_d;
    logic                 r_inc_q,   w_inc_d;
    logic                 r_great_q, w_great_d;
    logic                 r_good_q,  w_good_d;
    logic                 r_miss_q,  w_miss_d;
    logic                 w_match;

    always_comb begin
        w_state_d = r_state_q;
        w_timer_d = r_timer_q;
        w_type_d  = r_type_q;
        w_inc_d   = 1'b0;
        w_great_d = 1'b0;
        w_good_d  = 1'b0;
        w_miss_d  = 1'b0;

        // Exactly one pad edged and it is the pad the latched note asks for.
        w_match = (w_don_press ^ w_ka_press) &&
                  ((r_type_q == NOTE_DON) ? w_don_press : w_ka_press);

        if (!game_active) begin
            // Abandon silently; no miss for a window cut short by the game.
            w_state_d = ST_IDLE;
            w_timer_d = '0;
        end else begin
            case (r_state_q)
                ST_IDLE: begin
                    if (note_arrive) begin
                        w_state_d = ST_WINDOW;
                        w_timer_d = '0;
                        w_type_d  = note_type;
                    end
                end

                ST_WINDOW: begin
                    if (w_match && (r_timer_q < GREAT_T)) begin
                        w_inc_d   = 1'b1;
                        w_great_d = 1'b1;
                        w_state_d = ST_AWARD2;
                    end else if (w_match) begin
                        w_inc_d   = 1'b1;
                        w_good_d  = 1'b1;
                        w_state_d = ST_IDLE;
                    end else if (w_don_press || w_ka_press) begin
                        w_miss_d  = 1'b1;
                        w_state_d = ST_IDLE;
                    end else if (r_timer_q == LAST_T) begin
                        w_miss_d  = 1'b1;
                        w_state_d = ST_IDLE;
                    end else begin
                        w_timer_d = r_timer_q + TIMER_W'(1);
                    end

                    // A new note supersedes the current one; an unjudged note
                    // is scored as a miss on its way out.
                    if (note_arrive) begin
                        if (!(w_great_d || w_good_d || w_miss_d)) begin
                            w_miss_d = 1'b1;
                        end
                        w_state_d = ST_WINDOW;
                        w_timer_d = '0;
                        w_type_d  = note_type;
                    end
                end

                ST_AWARD2: begin
                    w_inc_d   = 1'b1;
                    w_state_d = ST_IDLE;
                    if (note_arrive) begin
                        w_state_d = ST_WINDOW;
                        w_timer_d = '0;
                        w_type_d  = note_type;
                    end
                end

                default: begin
                    w_state_d = ST_IDLE;
                    w_timer_d = '0;
                end
            endcase
        end

        if (w_miss_d) begin
            w_combo_d = '0;
        end else if (w_great_d || w_good_d) begin
            w_combo_d = combo_bump(r_combo_q);
        end else begin
            w_combo_d = r_combo_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q <= ST_IDLE;
            r_timer_q <= '0;
            r_type_q  <= NOTE_DON;
            r_combo_q <= '0;
            r_inc_q   <= 1'b0;
            r_great_q <= 1'b0;
            r_good_q  <= 1'b0;
            r_miss_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_timer_q <= w_timer_d;
            r_type_q  <= w_type_d;
            r_combo_q <= w_combo_d;
            r_inc_q   <= w_inc_d;
            r_great_q <= w_great_d;
            r_good_q  <= w_good_d;
            r_miss_q  <= w_miss_d;
        end
    end

    assign score_inc = r_inc_q;
    assign hit_great = r_great_q;
    assign hit_good  = r_good_q;
    assign hit_miss  = r_miss_q;
    assign combo     = r_combo_q;

endmodule : note_hit_judge
`default_nettype wire

// File: tb/tb_note_hit_judge.sv
`default_nettype none
// ============================================================================
// Module      : tb_note_hit_judge
// Description : Self-checking bench for note_hit_judge (WINDOW=8, GREAT=3).
//               Directed scenarios followed by random stimulus, all compared
//               cycle by cycle against a rule-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_note_hit_judge;

    localparam int W = 8;
    localparam int G = 3;

    logic       clock       = 1'b0;
    logic       reset       = 1'b1;
    logic       game_active = 1'b0;
    logic       note_arrive = 1'b0;
    logic       note_type   = 1'b0;
    logic       drum_don    = 1'b0;
    logic       drum_ka     = 1'b0;
    logic       score_inc;
    logic       hit_great;
    logic       hit_good;
    logic       hit_miss;
    logic [7:0] combo;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: "is a note open, how old is it, what type,
    // is a bonus point owed", plus the combo as a plain integer.
    bit m_open, m_bonus, m_type, m_prev_don, m_prev_ka;
    int m_age, m_combo;
    bit e_inc, e_great, e_good, e_miss;

    note_hit_judge #(
        .WINDOW_CYCLES (W),
        .GREAT_CYCLES  (G)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .game_active (game_active),
        .note_arrive (note_arrive),
        .note_type   (note_type),
        .drum_don    (drum_don),
        .drum_ka     (drum_ka),
        .score_inc   (score_inc),
        .hit_great   (hit_great),
        .hit_good    (hit_good),
        .hit_miss    (hit_miss),
        .combo       (combo)
    );

    always #5 clock = ~clock;

    // Predict from the inputs about to be sampled, clock once, then compare.
    task automatic tick();
        bit dp, kp, judged;
        dp = drum_don && !m_prev_don;
        kp = drum_ka  && !m_prev_ka;
        m_prev_don = reset ? 1'b0 : drum_don;
        m_prev_ka  = reset ? 1'b0 : drum_ka;
        e_inc = 0; e_great = 0; e_good = 0; e_miss = 0;
        judged = 0;
        if (reset) begin
            m_open = 0; m_bonus = 0; m_combo = 0;
        end else if (!game_active) begin
            m_open = 0; m_bonus = 0;
        end else if (m_bonus) begin
            e_inc = 1; m_bonus = 0;
            if (note_arrive) begin m_open = 1; m_age = 0; m_type = note_type; end
        end else if (m_open) begin
            if ((int'(dp) + int'(kp)) == 1 && (m_type ? kp : dp)) begin
                e_inc = 1; judged = 1;
                if (m_age < G) begin e_great = 1; m_bonus = 1; end
                else e_good = 1;
            end else if (dp || kp || m_age == W - 1) begin
                e_miss = 1; judged = 1;
            end
            if (judged) m_open = 0;
            else m_age++;
            if (note_arrive) begin
                if (!judged) e_miss = 1;
                m_open = 1; m_age = 0; m_type = note_type; m_bonus = 0;
            end
        end else if (note_arrive) begin
            m_open = 1; m_age = 0; m_type = note_type;
        end
        if (!reset) begin
            if (e_miss) m_combo = 0;
            else if ((e_great || e_good) && m_combo < 255) m_combo++;
        end

        @(posedge clock);
        #1;
        vectors++;
        assert ({score_inc, hit_great, hit_good, hit_miss, combo} ===
                {e_inc, e_great, e_good, e_miss, 8'(m_combo)})
        else begin
            miscompares++;
            $error("FAIL cycle%0d inc/great/good/miss/combo obs=%b%b%b%b/%0d exp=%b%b%b%b/%0d",
                   vectors, score_inc, hit_great, hit_good, hit_miss, combo,
                   e_inc, e_great, e_good, e_miss, m_combo);
        end
    endtask

    task automatic step(input bit arr, input bit typ, input bit don, input bit ka);
        note_arrive = arr;
        note_type   = typ;
        drum_don    = don;
        drum_ka     = ka;
        tick();
    endtask

    // Spot check against a hand-derived constant from the scenario.
    task automatic spot(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        spot("reset_combo", int'(combo), 0);
        spot("reset_inc", int'(score_inc), 0);
        reset = 1'b0;
        game_active = 1'b1;

        // Great: don note, press at timer 1
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        spot("great_strobe", int'(hit_great), 1);
        spot("great_combo", int'(combo), 1);
        step(0, 0, 0, 0);
        spot("great_second_inc", int'(score_inc), 1);
        spot("great_strobe_gone", int'(hit_great), 0);
        step(0, 0, 0, 0);
        spot("great_inc_done", int'(score_inc), 0);

        // Good: press at timer 5, then hold the pad through the next window
        step(1, 0, 0, 0);
        repeat (5) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        spot("good_strobe", int'(hit_good), 1);
        spot("good_combo", int'(combo), 2);
        step(1, 0, 1, 0);
        spot("good_single_inc", int'(score_inc), 0);
        repeat (8) step(0, 0, 1, 0);
        spot("held_miss", int'(hit_miss), 1);
        spot("held_no_score", int'(score_inc), 0);
        step(0, 0, 0, 0);

        // Timeout on a ka note
        step(1, 1, 0, 0);
        repeat (7) step(0, 1, 0, 0);
        spot("timeout_not_yet", int'(hit_miss), 0);
        step(0, 1, 0, 0);
        spot("timeout_miss", int'(hit_miss), 1);
        spot("timeout_combo", int'(combo), 0);

        // Wrong pad after rebuilding a combo
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        spot("wrong_pad_miss", int'(hit_miss), 1);
        spot("wrong_pad_combo", int'(combo), 0);
        step(0, 0, 0, 0);

        // Both pads in one cycle
        step(1, 1, 0, 0);
        step(0, 1, 1, 1);
        spot("both_pads_miss", int'(hit_miss), 1);
        step(0, 0, 0, 0);

        // Back-to-back: second arrival at timer 4 with no press
        step(1, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        spot("b2b_miss", int'(hit_miss), 1);
        step(0, 1, 0, 1);
        spot("b2b_new_great", int'(hit_great), 1);
        step(0, 0, 0, 0);

        // Arrival during AWARD2
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        spot("award2_inc", int'(score_inc), 1);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        spot("award2_new_great", int'(hit_great), 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Combo saturation
        for (int n = 0; n < 260; n++) begin
            step(1, 0, 0, 0);
            repeat (3) step(0, 0, 0, 0);
            step(0, 0, 1, 0);
            step(0, 0, 0, 0);
        end
        spot("combo_saturated", int'(combo), 255);

        // Disable mid-window
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        game_active = 1'b0;
        repeat (10) step(0, 1, 0, 0);
        spot("disable_no_miss", int'(hit_miss), 0);
        spot("disable_combo_held", int'(combo), 255);
        game_active = 1'b1;
        repeat (10) step(0, 0, 0, 0);

        // Reset mid-window
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        reset = 1'b1;
        step(0, 0, 1, 0);
        spot("reset_mid_combo", int'(combo), 0);
        spot("reset_mid_strobe", int'(hit_great | hit_good | hit_miss | score_inc), 0);
        reset = 1'b0;
        step(0, 0, 0, 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            reset       = ($urandom_range(0, 199) == 0);
            game_active = ($urandom_range(0, 49) != 0);
            note_arrive = ($urandom_range(0, 6) == 0);
            note_type   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) drum_don = ~drum_don;
            if ($urandom_range(0, 5) == 0) drum_ka  = ~drum_ka;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_note_hit_judge
`default_nettype wire
